// File: rtl/math_adder_multicycle.sv
// Sequential wide adder: sums WIDTH-bit operands CHUNK bits per clock through one N-bit adder.
// Optional signed-overflow output enabled by defining MATH_ADDER_MULTICYCLE_OVERFLOW_EN.

module math_adder_full_nbit #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out
);
    logic [N:0] carry;

    assign carry[0] = c_in;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_fa
            assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign c_out = carry[N];
endmodule

module math_adder_multicycle #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_c,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_busy
`ifdef MATH_ADDER_MULTICYCLE_OVERFLOW_EN
    ,
    output logic             o_overflow
`endif
);
    localparam int NUM_CHUNKS = WIDTH / ((CHUNK < 1) ? 1 : CHUNK);
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    generate
        if ((CHUNK < 1) || ((WIDTH % ((CHUNK < 1) ? 1 : CHUNK)) != 0)) begin : g_bad_cfg
            $error("math_adder_multicycle: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               carry_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [WIDTH-1:0]   sum_next;

    logic [CHUNK-1:0]   a_chunk [NUM_CHUNKS];
    logic [CHUNK-1:0]   b_chunk [NUM_CHUNKS];
    logic [CHUNK-1:0]   adder_sum;
    logic               adder_cout;

    generate
        for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_slice
            assign a_chunk[gi] = a_reg[gi*CHUNK +: CHUNK];
            assign b_chunk[gi] = b_reg[gi*CHUNK +: CHUNK];
        end
    endgenerate

    math_adder_full_nbit #(
        .N(CHUNK)
    ) u_adder (
        .a     (a_chunk[idx_reg]),
        .b     (b_chunk[idx_reg]),
        .c_in  (carry_reg),
        .sum   (adder_sum),
        .c_out (adder_cout)
    );

    // Merge the freshly computed slice into the partially built sum.
    always_comb begin
        sum_next = o_sum;
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                sum_next[i*CHUNK +: CHUNK] = adder_sum;
            end
        end
    end

`ifdef MATH_ADDER_MULTICYCLE_OVERFLOW_EN
    logic overflow_next;
    // Carry into the MSB xor carry out of it; only meaningful on the last slice.
    assign overflow_next = a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ adder_sum[CHUNK-1] ^ adder_cout;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= ST_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
            o_sum     <= '0;
            o_carry   <= 1'b0;
            o_valid   <= 1'b0;
            o_ready   <= 1'b1;
            o_busy    <= 1'b0;
`ifdef MATH_ADDER_MULTICYCLE_OVERFLOW_EN
            o_overflow <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_valid) begin
                        a_reg     <= i_a;
                        b_reg     <= i_b;
                        carry_reg <= i_c;
                        idx_reg   <= '0;
                        o_sum     <= '0;
                        o_ready   <= 1'b0;
                        o_busy    <= 1'b1;
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    o_sum     <= sum_next;
                    carry_reg <= adder_cout;
                    if (idx_reg == LAST_IDX) begin
                        o_carry   <= adder_cout;
`ifdef MATH_ADDER_MULTICYCLE_OVERFLOW_EN
                        o_overflow <= overflow_next;
`endif
                        idx_reg   <= '0;
                        o_valid   <= 1'b1;
                        state_reg <= ST_DONE;
                    end else begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        o_valid   <= 1'b0;
                        o_busy    <= 1'b0;
                        o_ready   <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    o_valid   <= 1'b0;
                    o_busy    <= 1'b0;
                    o_ready   <= 1'b1;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_math_adder_multicycle.sv
// Self-checking bench for math_adder_multicycle: directed vectors plus a per-cycle reference model.
// Overflow checks are compiled in when MATH_ADDER_MULTICYCLE_OVERFLOW_EN is defined.

module tb_math_adder_multicycle;
    localparam int WIDTH      = 32;
    localparam int CHUNK      = 8;
    localparam int NUM_CHUNKS = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_c;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_sum;
    logic             o_carry;
    logic             o_busy;
`ifdef MATH_ADDER_MULTICYCLE_OVERFLOW_EN
    logic             o_overflow;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    math_adder_multicycle #(
        .WIDTH(WIDTH),
        .CHUNK(CHUNK)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_c     (i_c),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_sum   (o_sum),
        .o_carry (o_carry),
        .o_busy  (o_busy)
`ifdef MATH_ADDER_MULTICYCLE_OVERFLOW_EN
        ,
        .o_overflow (o_overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a pending operation becomes visible NUM_CHUNKS edges after acceptance.
    logic          m_busy;
    logic          m_valid;
    int            m_cnt;
    logic [WIDTH:0] m_exp;
    logic [WIDTH:0] m_last;
    logic          m_ovf;
    logic          m_last_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy     = 1'b0;
            m_valid    = 1'b0;
            m_cnt      = 0;
            m_exp      = '0;
            m_last     = '0;
            m_ovf      = 1'b0;
            m_last_ovf = 1'b0;
        end else if (m_valid) begin
            if (i_ready) begin
                m_busy  = 1'b0;
                m_valid = 1'b0;
            end
        end else if (m_busy) begin
            m_cnt++;
            if (m_cnt == NUM_CHUNKS) begin
                m_valid    = 1'b1;
                m_last     = m_exp;
                m_last_ovf = m_ovf;
            end
        end else if (i_valid) begin
            m_busy = 1'b1;
            m_cnt  = 0;
            m_exp  = {1'b0, i_a} + {1'b0, i_b} + (WIDTH+1)'(i_c);
            m_ovf  = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (m_exp[WIDTH-1] != i_a[WIDTH-1]);
        end
    end

    always @(negedge clk) begin
        check("cmp_ready", 64'(o_ready), 64'(!m_busy));
        check("cmp_busy",  64'(o_busy),  64'(m_busy));
        check("cmp_valid", 64'(o_valid), 64'(m_valid));
        if (m_valid || !m_busy) begin
            check("cmp_sum",   64'(o_sum),   64'(m_last[WIDTH-1:0]));
            check("cmp_carry", 64'(o_carry), 64'(m_last[WIDTH]));
`ifdef MATH_ADDER_MULTICYCLE_OVERFLOW_EN
            check("cmp_ovf",   64'(o_overflow), 64'(m_last_ovf));
`endif
        end
    end

    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        @(negedge clk);
        i_a     = a;
        i_b     = b;
        i_c     = c;
        i_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        i_a     = '0;
        i_b     = '0;
        i_c     = 1'b0;
        $display("op accepted a=0x%08h b=0x%08h c=%0d", a, b, c);
    endtask

    // Edges are counted including the accepting edge.
    task automatic wait_valid(input string name, output int edges);
        edges = 1;
        while (!o_valid && edges < 30) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        if (!o_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got o_valid=0 expected 1 within 30 edges", name);
        end
    endtask

    task automatic finish_op(input string name, input logic [WIDTH-1:0] exp_sum, input logic exp_carry);
        int edges;
        wait_valid(name, edges);
        check({name, "_sum"},   64'(o_sum),   64'(exp_sum));
        check({name, "_carry"}, 64'(o_carry), 64'(exp_carry));
        $display("op %s result sum=0x%08h carry=%0d edges=%0d", name, o_sum, o_carry, edges);
        i_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_ready = 1'b0;
        check({name, "_ready_back"}, 64'(o_ready), 64'd1);
    endtask

    initial begin
        int edges;
        logic [WIDTH-1:0] held_sum;
        rst_n   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_a     = '0;
        i_b     = '0;
        i_c     = 1'b0;
        #2 rst_n = 1'b0;
        #10;
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_busy",  64'(o_busy),  64'd0);
        check("rst_sum",   64'(o_sum),   64'd0);
        check("rst_carry", 64'(o_carry), 64'd0);
        #10 rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 64'(o_ready), 64'd1);

        // Carry ripples through every chunk; latency counted from the accepting edge.
        i_ready = 1'b1;
        start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        wait_valid("wrap", edges);
        check("wrap_latency", 64'(edges), 64'd5);
        check("wrap_sum",     64'(o_sum),   64'h0);
        check("wrap_carry",   64'(o_carry), 64'd1);
        $display("op wrap result sum=0x%08h carry=%0d edges=%0d", o_sum, o_carry, edges);
        @(posedge clk);
        @(negedge clk);
        i_ready = 1'b0;
        check("wrap_ready_back", 64'(o_ready), 64'd1);
        check("wrap_valid_drop", 64'(o_valid), 64'd0);

        // Carry-in plus backpressure hold.
        start_op(32'h1234_5678, 32'h1111_1111, 1'b1);
        check("cin_ready_low", 64'(o_ready), 64'd0);
        wait_valid("cin", edges);
        check("cin_sum",   64'(o_sum),   64'h2345_678A);
        check("cin_carry", 64'(o_carry), 64'd0);
        held_sum = o_sum;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("hold_valid", 64'(o_valid), 64'd1);
            check("hold_sum",   64'(o_sum),   64'(held_sum));
            check("hold_ready", 64'(o_ready), 64'd0);
        end
        $display("op cin held sum=0x%08h carry=%0d for 6 cycles", o_sum, o_carry);
        i_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_ready = 1'b0;
        check("cin_ready_back", 64'(o_ready), 64'd1);

        // New operands presented during RUN must be ignored.
        start_op(32'hAAAA_0000, 32'h5556_FFFF, 1'b0);
        i_a     = 32'h1;
        i_b     = 32'h1;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        i_a     = '0;
        i_b     = '0;
        finish_op("ignore", 32'h0000_FFFF, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("ignore_no_second", 64'(o_valid), 64'd0);
        end

        // Reset during the second RUN cycle aborts the operation.
        start_op(32'h0F0F_0F0F, 32'h0101_0101, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_sum",   64'(o_sum),   64'd0);
        check("abort_carry", 64'(o_carry), 64'd0);
        check("abort_valid", 64'(o_valid), 64'd0);
        check("abort_busy",  64'(o_busy),  64'd0);
        $display("op aborted by reset sum=0x%08h valid=%0d", o_sum, o_valid);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready", 64'(o_ready), 64'd1);
        start_op(32'h5, 32'h3, 1'b0);
        finish_op("post_reset", 32'h8, 1'b0);

        // Signed-overflow boundary operands.
        start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        wait_valid("ovf_pos", edges);
        check("ovf_pos_sum",   64'(o_sum),   64'h8000_0000);
        check("ovf_pos_carry", 64'(o_carry), 64'd0);
`ifdef MATH_ADDER_MULTICYCLE_OVERFLOW_EN
        check("ovf_pos_flag",  64'(o_overflow), 64'd1);
`endif
        $display("op ovf_pos result sum=0x%08h carry=%0d", o_sum, o_carry);
        i_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_ready = 1'b0;

        start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        wait_valid("ovf_neg", edges);
        check("ovf_neg_sum",   64'(o_sum),   64'h0);
        check("ovf_neg_carry", 64'(o_carry), 64'd1);
`ifdef MATH_ADDER_MULTICYCLE_OVERFLOW_EN
        check("ovf_neg_flag",  64'(o_overflow), 64'd0);
`endif
        $display("op ovf_neg result sum=0x%08h carry=%0d", o_sum, o_carry);
        i_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_ready = 1'b0;

        start_op(32'h8000_0000, 32'h8000_0000, 1'b1);
        finish_op("neg_neg", 32'h0000_0001, 1'b1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
